// File: rtl/simple_pkg.sv
// Shared definitions for the run detector: default run length and the
// named states of the RUN_LEN=2 case.
package simple_pkg;

    localparam int RUN_LEN_DEF = 2;

    typedef enum logic [1:0] {
        ST_A = 2'b00,
        ST_B = 2'b01,
        ST_C = 2'b10
    } state_e;

endpackage

// File: rtl/simple_if.sv
// Level input and detector output of the run detector, grouped for
// board-level and testbench hookup.
interface simple_if;
    logic w;
    logic out;

    modport master (output w, input out);
    modport slave  (input w, output out);
endinterface

// File: rtl/clock_divider.sv
// Free-running 32-bit counter; bit k toggles at f/2^(k+1) and the board
// picks one bit as the slow clock for the run detector.
module clock_divider (
    input  logic        clock,
    output logic [31:0] divided_clocks
);

    logic [31:0] count = '0;

    always_ff @(posedge clock) begin
        count <= count + 32'd1;
    end

    assign divided_clocks = count;

endmodule

// File: rtl/simple_fsm.sv
// Saturating run counter: counts consecutive high samples of w and flags
// when the count reaches RUN_LEN.
//
// state (RUN_LEN=2) | meaning
// A  run=0          | idle, no high sample yet (or last sample low)
// B  run=1          | one high sample seen
// C  run=2          | run complete, out asserted while w stays high
module simple_fsm #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 2
) (
    input  logic     clk,
    input  logic     reset,
    simple_if.slave  bus
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            run <= '0;
        end else begin
            run <= run_nxt;
        end
    end

    // Encodings above RUN_MAX are unreachable; fall back to idle.
    always_comb begin
        run_nxt = '0;
        if (run > RUN_MAX) begin
            run_nxt = '0;
        end else if (!bus.w) begin
            run_nxt = '0;
        end else if (run < RUN_MAX) begin
            run_nxt = run + 1'b1;
        end else begin
            run_nxt = RUN_MAX;
        end
    end

    assign bus.out = (run == RUN_MAX);

endmodule

// File: rtl/simple.sv
// Moore run detector top: out asserts after RUN_LEN consecutive high samples
// of w and drops on the first low sample.
module simple
    import simple_pkg::*;
#(
    parameter  int RUN_LEN = RUN_LEN_DEF,
    localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic out
);

    simple_if bus ();

    assign bus.w = w;
    assign out   = bus.out;

    simple_fsm #(
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) u_fsm (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

endmodule

// File: tb/tb_simple.sv
// Bench for the run detector (RUN_LEN 2, 1, 5) and the clock divider, checked
// against a streak-length model and an edge count.
module tb_simple;

    logic        clk;
    logic        reset;
    logic        out_l1;
    logic        out_l5;
    logic [31:0] div;
    int unsigned edges;

    int errors = 0;
    int checks = 0;
    int streak = 0;

    simple_if bus ();

    simple #(.RUN_LEN(2)) dut (
        .clk   (clk),
        .reset (reset),
        .w     (bus.w),
        .out   (bus.out)
    );

    simple #(.RUN_LEN(1)) dut_l1 (
        .clk   (clk),
        .reset (reset),
        .w     (bus.w),
        .out   (out_l1)
    );

    simple #(.RUN_LEN(5)) dut_l5 (
        .clk   (clk),
        .reset (reset),
        .w     (bus.w),
        .out   (out_l5)
    );

    clock_divider u_div (
        .clock          (clk),
        .divided_clocks (div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; the model tracks the length of the
    // current high streak and each detector is high once it reaches its length.
    task automatic step(input logic r, input logic wv, input string tag);
        reset = r;
        bus.w = wv;
        @(posedge clk);
        if (r === 1'b1) streak = 0;
        else if (wv === 1'b1) streak++;
        else streak = 0;
        #1;
        chk({tag, "/len2"}, {31'd0, bus.out}, {31'd0, streak >= 2});
        chk({tag, "/len1"}, {31'd0, out_l1},  {31'd0, streak >= 1});
        chk({tag, "/len5"}, {31'd0, out_l5},  {31'd0, streak >= 5});
    endtask

    initial begin
        logic [31:0] prev;
        reset = 1'b1;
        bus.w = 1'bx;

        step(1'b1, 1'bx, "reset");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "idle");

        step(1'b0, 1'b1, "pulse_hi");
        step(1'b0, 1'b0, "pulse_lo");
        step(1'b0, 1'b0, "pulse_lo2");

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "run");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "run_drop");

        step(1'b0, 1'b1, "mid_a");
        step(1'b0, 1'b1, "mid_b");
        step(1'b1, 1'b1, "mid_reset");
        step(1'b0, 1'b1, "mid_rel1");
        step(1'b0, 1'b1, "mid_rel2");
        step(1'b0, 1'b0, "mid_end");

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "sweep");
        step(1'b0, 1'b0, "sweep_end");

        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, "long_run");
        step(1'b0, 1'b0, "long_end");

        for (int i = 0; i < 150; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), "random");
        end

        chk("div_count", div, edges);
        prev = div;
        @(posedge clk); #1;
        chk("div_bit0", {31'd0, div[0]}, {31'd0, ~prev[0]});
        chk("div_inc", div, prev + 32'd1);
        prev = div;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("div_bit1", {31'd0, div[1]}, {31'd0, ~prev[1]});
        chk("div_count2", div, edges);

        force u_div.count = 32'hFFFF_FFFF;
        #1;
        release u_div.count;
        #1;
        chk("div_forced", div, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("div_wrap", div, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
